// File: rtl/de2_pio_led_effects.sv
// Avalon-MM controlled LED effects stage sitting between the green-LED PIO
// and the DE2 LEDG[8:0] pins. Modes: pass-through, blink and PWM dim,
// all paced by a programmable prescaler.
//
// Bus handshake: there is no valid/ready pair on this slave. A write is
// accepted on every rising edge where chipselect=1 and write_n=0, and
// readdata is a purely combinational view of the addressed register
// (zero wait states, independent of chipselect).
module de2_pio_led_effects #(
    parameter logic [15:0] PRESCALE_RESET = 16'd49999,
    parameter logic [7:0]  DUTY_RESET     = 8'd128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [8:0]  led_in,
    output logic [8:0]  led_out
);

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_DUTY     = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    logic [2:0]  ctrl;
    logic [15:0] prescale;
    logic [7:0]  duty;
    logic [15:0] cnt;
    logic        phase;
    logic [7:0]  pwm_cnt;
    logic [8:0]  led_next;

    logic        wr;
    logic        enable;
    logic [1:0]  mode;
    logic        tick;
    logic        restart;
    logic        unused_bits;

    assign wr      = chipselect && !write_n;
    assign enable  = ctrl[2];
    assign mode    = ctrl[1:0];
    assign tick    = enable && (cnt == prescale);
    // Reprogramming the timebase restarts it so the first period is whole.
    assign restart = wr && ((address == ADDR_CTRL) || (address == ADDR_PRESCALE));
    assign unused_bits = ^writedata[31:16];

    // Register file writes; STATUS is read-only so address 3 is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl     <= 3'd0;
            prescale <= PRESCALE_RESET;
            duty     <= DUTY_RESET;
        end else if (wr) begin
            case (address)
                ADDR_CTRL:     ctrl     <= writedata[2:0];
                ADDR_PRESCALE: prescale <= writedata[15:0];
                ADDR_DUTY:     duty     <= writedata[7:0];
                default:       ;
            endcase
        end
    end

    // Prescaler, blink phase and PWM counter; a restart beats a tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= 16'd0;
            phase   <= 1'b1;
            pwm_cnt <= 8'd0;
        end else if (restart) begin
            cnt     <= 16'd0;
            phase   <= 1'b1;
            pwm_cnt <= 8'd0;
        end else if (tick) begin
            cnt     <= 16'd0;
            phase   <= ~phase;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else if (enable) begin
            cnt     <= cnt + 16'd1;
        end else begin
            cnt     <= 16'd0;
        end
    end

    // Effect selection from the current (possibly frozen) timebase state.
    always_comb begin
        led_next = led_in;
        case (mode)
            2'd1:    led_next = led_in & {9{phase}};
            2'd2:    led_next = led_in & {9{pwm_cnt < duty}};
            default: led_next = led_in;
        endcase
    end

    // Registered LED drive, one cycle behind led_in in every mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_out <= 9'h000;
        end else begin
            led_out <= led_next;
        end
    end

    // Combinational read mux, zero-extended.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CTRL:     readdata = {29'd0, ctrl};
            ADDR_PRESCALE: readdata = {16'd0, prescale};
            ADDR_DUTY:     readdata = {24'd0, duty};
            ADDR_STATUS:   readdata = {16'd0, pwm_cnt, 7'd0, phase};
            default:       readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_de2_pio_led_effects.sv
// Bench for de2_pio_led_effects: reset checks, a table of single-cycle
// register/mode vectors, then hand-written blink, dim, restart and
// mid-run reset sequences with hand-derived expectations.
module tb_de2_pio_led_effects;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [8:0]  led_in;
    logic [8:0]  led_out;

    int n_checks;
    int n_fail;

    de2_pio_led_effects dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [8:0]  led;
        logic [8:0]  exp_led;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick_cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] e);
        address = a;
        #1;
        chk(nm, readdata, e);
    endtask

    // Blink with PRESCALE=3 started by a CTRL write at edge E0: phase
    // seen at edge Ek is 1 for k=1..4, 0 for 5..8, ...
    task automatic blink_run(input int n);
        for (int k = 1; k <= n; k++) begin
            logic [8:0]  e_led;
            logic [31:0] e_st;
            logic [7:0]  e_pwm;
            tick_cycle();
            e_led = ((((k - 1) / 4) % 2) == 0) ? 9'h155 : 9'h000;
            chk("blink_led", {23'd0, led_out}, {23'd0, e_led});
            e_pwm = 8'(k / 4);
            e_st  = {16'd0, e_pwm, 7'd0, (((k / 4) % 2) == 0)};
            rd_chk("blink_status", 2'd3, e_st);
        end
    endtask

    // Dim with PRESCALE=0 for one full 256-tick period.
    task automatic dim_run(input logic [7:0] d, input int exp_ones);
        int ones;
        int bad;
        ones = 0;
        bad  = 0;
        wr_reg(2'd2, {24'd0, d});
        wr_reg(2'd0, 32'd6);
        for (int k = 1; k <= 256; k++) begin
            tick_cycle();
            if (led_out == 9'h0F3) ones++;
            if (led_out !== ((k - 1 < int'(d)) ? 9'h0F3 : 9'h000)) bad++;
        end
        chk("dim_on_count", ones, exp_ones);
        chk("dim_pattern_errors", bad, 0);
        rd_chk("dim_status_wrap", 2'd3, 32'h0000_0001);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        led_in     = 9'h1FF;

        //           addr  wr    wdata         led     exp_led exp_rd
        vecs[0]  = '{2'd1, 1'b0, 32'd0,        9'h1FF, 9'h1FF, 32'd49999};
        vecs[1]  = '{2'd2, 1'b0, 32'd0,        9'h0AA, 9'h0AA, 32'd128};
        vecs[2]  = '{2'd0, 1'b0, 32'd0,        9'h155, 9'h155, 32'd0};
        vecs[3]  = '{2'd3, 1'b0, 32'd0,        9'h155, 9'h155, 32'd1};
        vecs[4]  = '{2'd1, 1'b1, 32'hFFFF0003, 9'h155, 9'h155, 32'd3};
        vecs[5]  = '{2'd2, 1'b1, 32'h00000140, 9'h155, 9'h155, 32'h40};
        vecs[6]  = '{2'd3, 1'b1, 32'h0000FFFF, 9'h155, 9'h155, 32'd1};
        vecs[7]  = '{2'd0, 1'b1, 32'hFFFFFFF8, 9'h155, 9'h155, 32'd0};
        vecs[8]  = '{2'd0, 1'b1, 32'd3,        9'h0F0, 9'h0F0, 32'd3};
        vecs[9]  = '{2'd0, 1'b0, 32'd0,        9'h101, 9'h101, 32'd3};
        vecs[10] = '{2'd0, 1'b1, 32'd1,        9'h1FF, 9'h1FF, 32'd1};
        vecs[11] = '{2'd3, 1'b0, 32'd0,        9'h1FF, 9'h1FF, 32'd1};
        vecs[12] = '{2'd0, 1'b1, 32'd2,        9'h1FF, 9'h1FF, 32'd2};
        vecs[13] = '{2'd3, 1'b0, 32'd0,        9'h1FF, 9'h1FF, 32'd1};
        vecs[14] = '{2'd2, 1'b1, 32'd0,        9'h1FF, 9'h1FF, 32'd0};
        vecs[15] = '{2'd2, 1'b0, 32'd0,        9'h1FF, 9'h000, 32'd0};
        vecs[16] = '{2'd0, 1'b1, 32'd0,        9'h0AA, 9'h000, 32'd0};
        vecs[17] = '{2'd0, 1'b0, 32'd0,        9'h0AA, 9'h0AA, 32'd0};

        // Reset with led_in all ones
        tick_cycle();
        chk("reset_led_1", {23'd0, led_out}, 32'd0);
        tick_cycle();
        chk("reset_led_2", {23'd0, led_out}, 32'd0);
        reset_n = 1'b1;
        tick_cycle();
        chk("release_led", {23'd0, led_out}, 32'h1FF);

        // Register map and mode vectors
        for (int i = 0; i < 18; i++) begin
            address    = vecs[i].addr;
            chipselect = vecs[i].wr;
            write_n    = !vecs[i].wr;
            writedata  = vecs[i].wdata;
            led_in     = vecs[i].led;
            tick_cycle();
            chk($sformatf("vec%0d_led", i), {23'd0, led_out}, {23'd0, vecs[i].exp_led});
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Blink, freeze, resume
        led_in = 9'h155;
        wr_reg(2'd1, 32'd3);
        wr_reg(2'd0, 32'd5);
        blink_run(16);
        wr_reg(2'd0, 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick_cycle();
            chk("frozen_led", {23'd0, led_out}, 32'h155);
            rd_chk("frozen_status", 2'd3, 32'd1);
        end
        wr_reg(2'd0, 32'd5);
        blink_run(8);

        // Restart: STATUS write ignored, PRESCALE write on a tick edge
        wr_reg(2'd0, 32'd5);
        wr_reg(2'd3, 32'hFFFFFFFF);
        rd_chk("status_write_ignored", 2'd3, 32'd1);
        tick_cycle();
        tick_cycle();
        wr_reg(2'd1, 32'd3);
        rd_chk("restart_on_tick", 2'd3, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick_cycle();
            rd_chk("restart_count", 2'd3, 32'd1);
        end
        tick_cycle();
        rd_chk("restart_first_tick", 2'd3, 32'h100);
        chk("restart_led", {23'd0, led_out}, 32'h155);

        // Dim
        led_in = 9'h0F3;
        wr_reg(2'd1, 32'd0);
        dim_run(8'd64, 64);
        dim_run(8'd0, 0);
        dim_run(8'd255, 255);
        wr_reg(2'd2, 32'd10);
        rd_chk("duty_write_keeps_pwm", 2'd3, 32'h100);

        // Reset mid-blink, colliding with a write
        led_in = 9'h155;
        wr_reg(2'd1, 32'd3);
        wr_reg(2'd2, 32'd33);
        wr_reg(2'd0, 32'd5);
        repeat (5) tick_cycle();
        reset_n    = 1'b0;
        address    = 2'd1;
        writedata  = 32'd7;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick_cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b1;
        chk("midreset_led", {23'd0, led_out}, 32'd0);
        rd_chk("midreset_ctrl", 2'd0, 32'd0);
        rd_chk("midreset_prescale", 2'd1, 32'd49999);
        rd_chk("midreset_duty", 2'd2, 32'd128);
        rd_chk("midreset_status", 2'd3, 32'd1);
        tick_cycle();
        chk("post_reset_pass", {23'd0, led_out}, 32'h155);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/de2_pio_led_effects.md
DE2_PIO_LED_EFFECTS -- requirements
Module: de2_pio_led_effects

Interface
REQ-001 The block SHALL have parameter PRESCALE_RESET, default 16'd49999, giving the reset value of the PRESCALE register.
REQ-002 The block SHALL have parameter DUTY_RESET, default 8'd128, giving the reset value of the DUTY register.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, on the ports clk and reset_n.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  Avalon-MM write strobe, active low.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 readdata  output  32  Avalon-MM read data; combinational, zero wait states.
REQ-011 led_in  input  9  LED pattern from the upstream green-LED PIO out_port.
REQ-012 led_out  output  9  registered drive to the DE2 green LEDs LEDG[8:0].

Function
REQ-013 A write SHALL occur when chipselect=1 and write_n=0; it takes effect on that rising edge.
REQ-014 Register map SHALL be: addr0 CTRL (bits[1:0] mode, bit2 enable); addr1 PRESCALE[15:0]; addr2 DUTY[7:0]; addr3 STATUS, read-only (bit0 phase, bits[15:8] pwm_cnt).
REQ-015 Writes to addr3 SHALL be ignored; unused writedata bits SHALL be ignored.
REQ-016 readdata SHALL be the addressed register, zero-extended to 32 bits, independent of chipselect.
REQ-017 The prescaler counter SHALL count 0..PRESCALE while enable=1; at count==PRESCALE it SHALL return to 0 and assert an internal tick for exactly one cycle.
REQ-018 PRESCALE=0 SHALL give a tick every cycle while enabled.
REQ-019 enable=0 SHALL hold the prescaler at 0, suppress ticks, and freeze phase and pwm_cnt.
REQ-020 Each tick SHALL toggle phase and increment pwm_cnt modulo 256 (255 wraps to 0).
REQ-021 A write to CTRL or PRESCALE SHALL reset prescaler count to 0, phase to 1 and pwm_cnt to 0 on that edge; if a tick coincides, the write wins.
REQ-022 Mode 0 (pass): led_out SHALL equal led_in delayed by one cycle.
REQ-023 Mode 1 (blink): led_out SHALL equal led_in AND {9{phase}}, registered, one-cycle latency.
REQ-024 Mode 2 (dim): led_out SHALL equal led_in AND {9{pwm_cnt < DUTY}}, registered; DUTY=0 SHALL give constant 0; DUTY=255 SHALL be off for exactly 1 of 256 ticks.
REQ-025 Mode 3 SHALL behave as mode 0.
REQ-026 A DUTY write SHALL take effect on the compare in the following cycle without disturbing pwm_cnt.
REQ-027 With enable=0, modes 1 and 2 SHALL use the frozen phase/pwm_cnt values; led_in changes still propagate with one-cycle latency.

Reset
REQ-028 On a rising edge with reset_n=0: CTRL=0, PRESCALE=PRESCALE_RESET, DUTY=DUTY_RESET, prescaler count=0, phase=1, pwm_cnt=0, led_out=9'h000.
REQ-029 Reset SHALL take priority over any simultaneous write and SHALL abort any operation in progress.
REQ-030 reset_n deasserting between edges SHALL have no effect until the next rising edge.

Verification
REQ-031 Reset, led_in=9'h1FF, CTRL=0 -> led_out=9'h000 during reset, 9'h1FF one cycle after reset release; readdata addr1=49999, addr2=128.
REQ-032 PRESCALE=3, CTRL=5 (blink, enabled), led_in=9'h155 -> led_out alternates 9'h155/9'h000, changing every 4 cycles.
REQ-033 PRESCALE=0, DUTY=64, CTRL=6 -> led_out=led_in for 64 of every 256 cycles; DUTY=0 -> constant 0; DUTY=255 -> 255 of 256.
REQ-034 Blink running, write CTRL with bit2=0 -> phase and STATUS frozen, no further toggles; re-enable -> toggling resumes from phase=1.
REQ-035 Write PRESCALE on same edge as a tick -> count=0, phase=1, pwm_cnt=0 next cycle; write to addr3 -> STATUS unchanged.
REQ-036 reset_n=0 for one edge mid-blink -> all registers and led_out return to REQ-028 values.
